// File: rtl/hazard_unit_mc_pkg.sv
// Shared constants for the multi-cycle MIPS hazard unit: forwarding select
// encodings and default latency / width parameters.
`timescale 1ns/1ps
package mips_hazard_pkg;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_MULT_LAT    = 4;
    localparam int DEF_DIV_LAT     = 32;
    localparam int DEF_MEM_TIMEOUT = 255;
endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard unit signal bundle. The datapath is the master; the
// hazard unit (slave) returns stall/flush/forward controls.
`timescale 1ns/1ps
interface hazard_unit_mc_if #(parameter int REG_ADDR_W = 5);
    logic [REG_ADDR_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic BranchD, BranchTakenD, HiLoReadD, MultDivD;
    logic MemtoRegE, RegWriteE, MultE, DivE;
    logic MemtoRegM, RegWriteM, MemReqM, MemReadyM;
    logic RegWriteW;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushW;
    logic ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic MdBusy, MemTimeout;

    // Memory handshake: MemReqM is the request (valid); the access completes
    // in any cycle where MemReadyM is high alongside it. Ready may already be
    // high when the request appears (zero wait); the request is held until then.
    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output BranchD, BranchTakenD, HiLoReadD, MultDivD,
        output MemtoRegE, RegWriteE, MultE, DivE,
        output MemtoRegM, RegWriteM, MemReqM, MemReadyM, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy, MemTimeout
    );
    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input  BranchD, BranchTakenD, HiLoReadD, MultDivD,
        input  MemtoRegE, RegWriteE, MultE, DivE,
        input  MemtoRegM, RegWriteM, MemReqM, MemReadyM, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy, MemTimeout
    );
endinterface

// File: rtl/hazard_unit_mc_md_busy_counter.sv
// HI/LO busy countdown: loads a latency when a mult/div issues, then counts
// down to zero; busy while non-zero.
`timescale 1ns/1ps
module md_busy_counter #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = $clog2(DIV_LAT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load_div,
    input  logic load_mult,
    output logic busy
);
    logic [CNT_W-1:0] md_cnt;

    // A load always overrides an in-flight count; divide wins over multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (en && load_div) begin
            md_cnt <= CNT_W'(DIV_LAT);
        end else if (en && load_mult) begin
            md_cnt <= CNT_W'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign busy = (md_cnt != '0);
endmodule

// File: rtl/hazard_unit_mc.sv
// Five-stage MIPS hazard unit with multi-cycle mult/div tracking, variable
// latency memory stalls and a sticky memory-timeout flag.
`timescale 1ns/1ps
module hazard_unit_mc
    import mips_hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MULT_LAT    = DEF_MULT_LAT,
    parameter int DIV_LAT     = DEF_DIV_LAT,
    parameter int CNT_W       = $clog2(DIV_LAT + 1),
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_unit_mc_if.slave hz
);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam int                    MW_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MW_W-1:0]       MW_MAX   = MW_W'(MEM_TIMEOUT);

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic [REG_ADDR_W-1:0] dst_m,
                                           input logic                  we_m,
                                           input logic [REG_ADDR_W-1:0] dst_w,
                                           input logic                  we_w);
        if (src != ZERO_REG && src == dst_m && we_m)      return FWD_M;
        else if (src != ZERO_REG && src == dst_w && we_w) return FWD_W;
        else                                              return FWD_NONE;
    endfunction

    logic mem_stall, lw_stall, branch_stall, md_stall, d_stall;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic md_busy, mem_timeout;
    logic [MW_W-1:0] mem_wait_cnt;

    assign hz.ForwardAE = fwd_sel(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    assign hz.ForwardAD = (hz.RsD != ZERO_REG) && (hz.RsD == hz.WriteRegM) && hz.RegWriteM;
    assign hz.ForwardBD = (hz.RtD != ZERO_REG) && (hz.RtD == hz.WriteRegM) && hz.RegWriteM;

    assign mem_stall    = hz.MemReqM && !hz.MemReadyM;
    assign lw_stall     = hz.MemtoRegE && ((hz.RsD == hz.RtE) || (hz.RtD == hz.RtE));
    assign branch_stall = hz.BranchD &&
        ((hz.RegWriteE && hz.WriteRegE != ZERO_REG &&
          (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
         (hz.MemtoRegM && hz.WriteRegM != ZERO_REG &&
          (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
    assign md_stall     = (hz.HiLoReadD || hz.MultDivD) && md_busy;
    assign d_stall      = lw_stall || branch_stall || md_stall;

    // A memory stall freezes the whole pipe and bubbles W; decode stalls only
    // hold F/D and bubble E. Everything is held low during reset.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst_n) begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (d_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            flush_d = hz.BranchTakenD && !stall_d && !mem_stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wait_cnt <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            if (mem_stall && mem_wait_cnt == MW_MAX) mem_timeout <= 1'b1;
            if (!mem_stall)                   mem_wait_cnt <= '0;
            else if (mem_wait_cnt != MW_MAX)  mem_wait_cnt <= mem_wait_cnt + 1'b1;
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (!stall_e),
        .load_div  (hz.DivE),
        .load_mult (hz.MultE),
        .busy      (md_busy)
    );

    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.StallM     = stall_m;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushW     = flush_w;
    assign hz.MdBusy     = md_busy;
    assign hz.MemTimeout = mem_timeout;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_hazard_unit_mc;
    localparam int RW = 5;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int MEM_TIMEOUT = 255;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // model state
    int   md_rem;
    int   mem_wait;
    bit   timeout;

    hazard_unit_mc_if #(.REG_ADDR_W(RW)) hz ();

    hazard_unit_mc #(
        .REG_ADDR_W (RW),
        .MULT_LAT   (MULT_LAT),
        .DIV_LAT    (DIV_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input int src, input int dm, input bit wm,
                                         input int dw, input bit ww);
        if (src != 0 && src == dm && wm) return 2'b10;
        if (src != 0 && src == dw && ww) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_mem_stall();
        return hz.MemReqM && !hz.MemReadyM;
    endfunction

    task automatic check_outputs();
        bit mem, lw, br, md, d;
        bit sf, sd, se, sm, fd, fe, fw;
        mem = m_mem_stall();
        lw  = hz.MemtoRegE && (hz.RsD == hz.RtE || hz.RtD == hz.RtE);
        br  = hz.BranchD &&
              ((hz.RegWriteE && hz.WriteRegE != 0 && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
               (hz.MemtoRegM && hz.WriteRegM != 0 && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
        md  = (hz.HiLoReadD || hz.MultDivD) && (md_rem > 0);
        d   = lw || br || md;
        {sf, sd, se, sm, fd, fe, fw} = '0;
        if (rst_n) begin
            if (mem) {sf, sd, se, sm, fw} = 5'b11111;
            else if (d) {sf, sd, fe} = 3'b111;
            fd = hz.BranchTakenD && !sd && !mem;
        end
        check("StallF", hz.StallF, sf);
        check("StallD", hz.StallD, sd);
        check("StallE", hz.StallE, se);
        check("StallM", hz.StallM, sm);
        check("FlushD", hz.FlushD, fd);
        check("FlushE", hz.FlushE, fe);
        check("FlushW", hz.FlushW, fw);
        check("ForwardAE", hz.ForwardAE, m_fwd(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW));
        check("ForwardBE", hz.ForwardBE, m_fwd(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW));
        check("ForwardAD", hz.ForwardAD, hz.RsD != 0 && hz.RsD == hz.WriteRegM && hz.RegWriteM);
        check("ForwardBD", hz.ForwardBD, hz.RtD != 0 && hz.RtD == hz.WriteRegM && hz.RegWriteM);
        check("MdBusy", hz.MdBusy, md_rem > 0);
        check("MemTimeout", hz.MemTimeout, timeout);
    endtask

    // advance model state across one rising edge, using inputs held at the edge
    task automatic model_step();
        bit mem;
        if (!rst_n) return;
        mem = m_mem_stall();
        if (!mem && hz.DivE)       md_rem = DIV_LAT;
        else if (!mem && hz.MultE) md_rem = MULT_LAT;
        else if (md_rem > 0)       md_rem--;
        if (mem && mem_wait == MEM_TIMEOUT) timeout = 1;
        mem_wait = mem ? ((mem_wait < MEM_TIMEOUT) ? mem_wait + 1 : MEM_TIMEOUT) : 0;
    endtask

    // called at a negedge with inputs already set; returns StallD seen this cycle
    task automatic step(output logic sd);
        #1;
        sd = hz.StallD;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {hz.RsD, hz.RtD, hz.RsE, hz.RtE} = '0;
        {hz.WriteRegE, hz.WriteRegM, hz.WriteRegW} = '0;
        {hz.BranchD, hz.BranchTakenD, hz.HiLoReadD, hz.MultDivD} = '0;
        {hz.MemtoRegE, hz.RegWriteE, hz.MultE, hz.DivE} = '0;
        {hz.MemtoRegM, hz.RegWriteM, hz.MemReqM, hz.MemReadyM, hz.RegWriteW} = '0;
    endtask

    task automatic model_reset();
        md_rem = 0;
        mem_wait = 0;
        timeout = 0;
    endtask

    logic sd;
    int   cnt;

    initial begin
        n_tests = 0;
        n_fail = 0;
        model_reset();
        clear_inputs();
        rst_n = 1'b0;
        // reset: a pending memory stall must still be masked
        hz.MemReqM = 1'b1;
        hz.BranchTakenD = 1'b1;
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // EX/EX forwarding: M wins over W; r0 never forwards
        hz.WriteRegM = 5; hz.RegWriteM = 1; hz.WriteRegW = 5; hz.RegWriteW = 1; hz.RsE = 5;
        #1 check("fwd_m_over_w", hz.ForwardAE, 2'b10);
        step(sd);
        hz.RsE = 0;
        #1 check("fwd_r0", hz.ForwardAE, 2'b00);
        step(sd);
        clear_inputs();

        // load-use stall, then no stall without MemtoRegE
        hz.MemtoRegE = 1; hz.RtE = 8; hz.RtD = 8;
        step(sd);
        check("lw_stall", sd, 1'b1);
        hz.MemtoRegE = 0; hz.RsD = 8; hz.RtD = 0;
        step(sd);
        check("no_lw_stall", sd, 1'b0);
        clear_inputs();

        // divide then mfhi: StallD for exactly DIV_LAT cycles
        hz.DivE = 1;
        step(sd);
        hz.DivE = 0; hz.HiLoReadD = 1;
        cnt = 0;
        for (int i = 0; i < DIV_LAT + 8; i++) begin
            step(sd);
            if (sd) cnt++;
        end
        check("div_stall_cycles", cnt, DIV_LAT);
        // multiply: MULT_LAT cycles
        hz.HiLoReadD = 0; hz.MultE = 1;
        step(sd);
        hz.MultE = 0; hz.MultDivD = 1;
        cnt = 0;
        for (int i = 0; i < MULT_LAT + 4; i++) begin
            step(sd);
            if (sd) cnt++;
        end
        check("mult_stall_cycles", cnt, MULT_LAT);
        clear_inputs();

        // memory wait 3 cycles with concurrent load-use: no FlushE
        hz.MemReqM = 1; hz.MemReadyM = 0; hz.MemtoRegE = 1; hz.RtE = 3; hz.RsD = 3;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (hz.StallM && hz.FlushW && !hz.FlushE) cnt++;
            step(sd);
        end
        check("mem_wait_cycles", cnt, 3);
        hz.MemReadyM = 1;
        #1 check("mem_ready_lw_flushe", hz.FlushE, 1'b1);
        step(sd);
        clear_inputs();
        // zero-latency memory
        hz.MemReqM = 1; hz.MemReadyM = 1;
        step(sd);
        check("zero_wait_no_stall", sd, 1'b0);

        // timeout: 255 stalled edges not enough, 256th sets it
        hz.MemReadyM = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) step(sd);
        #1 check("timeout_not_yet", hz.MemTimeout, 1'b0);
        step(sd);
        check("timeout_set", hz.MemTimeout, 1'b1);
        hz.MemReadyM = 1;
        step(sd);
        step(sd);
        check("timeout_sticky", hz.MemTimeout, 1'b1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("timeout_cleared", hz.MemTimeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // taken branch with and without a branch stall
        hz.BranchTakenD = 1;
        step(sd);
        hz.BranchD = 1; hz.RegWriteE = 1; hz.WriteRegE = 3; hz.RsD = 3;
        #1 check("branch_stall_no_flushd", hz.FlushD, 1'b0);
        step(sd);
        clear_inputs();

        // reset mid-divide clears MdBusy immediately
        hz.DivE = 1;
        step(sd);
        hz.DivE = 0;
        for (int i = 0; i < 5; i++) step(sd);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("rst_mid_div_mdbusy", hz.MdBusy, 1'b0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            hz.RsD = RW'($urandom_range(0, 3));
            hz.RtD = RW'($urandom_range(0, 3));
            hz.RsE = RW'($urandom_range(0, 3));
            hz.RtE = RW'($urandom_range(0, 3));
            hz.WriteRegE = RW'($urandom_range(0, 3));
            hz.WriteRegM = RW'($urandom_range(0, 3));
            hz.WriteRegW = RW'($urandom_range(0, 3));
            hz.BranchD = 1'($urandom_range(0, 1));
            hz.BranchTakenD = 1'($urandom_range(0, 1));
            hz.HiLoReadD = ($urandom_range(0, 3) == 0);
            hz.MultDivD = ($urandom_range(0, 3) == 0);
            hz.MemtoRegE = 1'($urandom_range(0, 1));
            hz.RegWriteE = 1'($urandom_range(0, 1));
            hz.MultE = ($urandom_range(0, 15) == 0);
            hz.DivE = ($urandom_range(0, 31) == 0);
            hz.MemtoRegM = 1'($urandom_range(0, 1));
            hz.RegWriteM = 1'($urandom_range(0, 1));
            hz.MemReqM = 1'($urandom_range(0, 1));
            hz.MemReadyM = ($urandom_range(0, 3) != 0);
            hz.RegWriteW = 1'($urandom_range(0, 1));
            step(sd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the 5-stage MIPS hazard unit.
- Adds a multi-cycle multiply/divide unit with a busy countdown and variable-latency data memory via a ready handshake in M.
- Adds a sticky memory-timeout flag and register-address width as a parameter.
- Sits beside the datapath and drives stall/flush/forward controls for the F/D/E/M/W pipeline registers; all stall/flush outputs are active-high.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MULT_LAT, 4, cycles HI/LO stay busy after a multiply issues from E.
- DIV_LAT, 32, cycles HI/LO stay busy after a divide issues from E.
- CNT_W, $clog2(DIV_LAT+1), countdown width; must hold max(MULT_LAT, DIV_LAT).
- MEM_TIMEOUT, 255, consecutive not-ready cycles in M before MemTimeout sets.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- RsD, RtD  in  REG_ADDR_W each  Decode source registers
- BranchD  in  1  branch in D
- BranchTakenD  in  1  branch resolved taken in D
- HiLoReadD  in  1  mfhi/mflo in D
- MultDivD  in  1  mult/div in D
- RsE, RtE, WriteRegE  in  REG_ADDR_W each  Execute registers
- MemtoRegE, RegWriteE  in  1 each  Execute controls
- MultE, DivE  in  1 each  multiply/divide issuing from E
- WriteRegM  in  REG_ADDR_W  Mem destination
- MemtoRegM, RegWriteM, MemReqM  in  1 each  Mem controls; MemReqM is a load/store in M
- MemReadyM  in  1  memory ready; completes the M access
- WriteRegW  in  REG_ADDR_W  Writeback destination
- RegWriteW  in  1  Writeback write enable
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline register
- FlushD, FlushE, FlushW  out  1 each  bubble into pipeline register
- ForwardAD, ForwardBD  out  1 each  M->D branch-compare forward
- ForwardAE, ForwardBE  out  2 each  2'b10 from M, 2'b01 from W, 2'b00 none
- MdBusy  out  1  HI/LO result pending
- MemTimeout  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - md_cnt and mem_wait_cnt clear to 0; MemTimeout clears to 0.
  - All stall and flush outputs are forced to 0 while rst_n is low.
  - Forwarding outputs stay purely combinational.
- Forwarding, combinational:
  - ForwardAE = 10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 01 if RsE!=0 && RsE==WriteRegW && RegWriteW; else 00.
  - ForwardBE is identical using RtE.
  - ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM; ForwardBD uses RtD.
- memStall = MemReqM && !MemReadyM.
- lwStall = MemtoRegE && (RsD==RtE || RtD==RtE). Precedence is explicit.
- branchStall = BranchD && ((RegWriteE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD)) || (MemtoRegM && WriteRegM!=0 && (WriteRegM==RsD || WriteRegM==RtD))).
- mdStall = (HiLoReadD || MultDivD) && MdBusy.
- dStall = lwStall || branchStall || mdStall.
- Priority 1, memStall:
  - StallF = StallD = StallE = StallM = 1; FlushW = 1.
  - FlushD = FlushE = 0.
  - dStall is ignored this cycle.
- Priority 2, dStall (with !memStall): StallF = StallD = 1, FlushE = 1; StallE = StallM = FlushW = 0.
- Priority 3, taken branch: FlushD = BranchTakenD && !StallD && !memStall.
- MD countdown:
  - MdBusy = (md_cnt != 0).
  - On a clock edge with !StallE and DivE: load DIV_LAT. Else with !StallE and MultE: load MULT_LAT. DivE wins if both are set.
  - Otherwise, if md_cnt != 0, decrement by 1; it saturates at 0.
  - Load while busy cannot happen because D stalls; if forced, the load overrides.
  - Countdown continues during memStall.
- Memory wait:
  - mem_wait_cnt increments each cycle memStall is 1 and saturates at MEM_TIMEOUT.
  - It clears on any cycle memStall is 0.
  - MemTimeout sets when mem_wait_cnt==MEM_TIMEOUT && memStall; it clears only on reset.
- Zero-latency memory: MemReadyM already high while MemReqM is high produces no stall.

Decomposition:
- Shared package mips_hazard_pkg: FWD_NONE/FWD_W/FWD_M 2-bit constants; default latency constants.
- One natural sub-module, md_busy_counter: parametrised load/decrement countdown with busy output.
- Forwarding and stall logic stay in the top module.

Test Plan:
- EX/EX forward: WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1, RsE=5 -> ForwardAE=10. Same with RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RtD=8 -> StallF=StallD=FlushE=1 for one cycle. With MemtoRegE=0 and RsD=RtE=8 -> no stall.
- Divide then mfhi: DivE pulse, then HiLoReadD=1 -> StallD=1 for exactly 32 cycles (DIV_LAT=32), released when MdBusy falls. Multiply -> 4 cycles.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles -> StallF..StallM=1 and FlushW=1 for 3 cycles. A concurrent lwStall produces no FlushE.
- Timeout: MemReadyM held low 256 cycles (MEM_TIMEOUT=255) -> MemTimeout sets and stays high after MemReadyM rises; rst_n pulse clears it.
- Taken branch plus reset: BranchTakenD=1 with no stall -> FlushD=1. Same cycle with branchStall -> FlushD=0. rst_n asserted mid-divide -> MdBusy=0 immediately.
